// File: rtl/armleo_axi_pkg.sv
// armleo_axi_pkg: shared AXI encodings, host-index width and ID concatenation helper
package armleo_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  // One spare code point so out-of-range host indices remain representable on rid
  function automatic int hidx_w(input int host_number);
    return $clog2(host_number + 1);
  endfunction
  function automatic logic [31:0] make_id(input logic [31:0] hidx, input logic [31:0] id, input int id_w);
    return (hidx << id_w) | id;
  endfunction
endpackage

// File: rtl/armleo_axi_ar_slice.sv
// armleo_axi_ar_slice: two-entry full-throughput register slice with registered s_ready
module armleo_axi_ar_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);
  logic [W-1:0] mem_q [2];
  logic wp_q, rp_q, push, pop;
  logic [1:0] cnt_q;
  assign s_ready_o = cnt_q != 2'd2;
  assign m_valid_o = cnt_q != 2'd0;
  assign m_data_o = mem_q[rp_q];
  assign push = s_valid_i & s_ready_o;
  assign pop = m_valid_o & m_ready_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= s_data_i;
      wp_q <= wp_q ^ push;
      rp_q <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/armleo_round_robin.sv
// armleo_round_robin: round-robin arbiter, pointer moves past the index acknowledged
module armleo_round_robin #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic             adv_i,
  input  logic [IDX_W-1:0] adv_idx_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      for (int j = 0; j < WIDTH; j++)
        if (req_i[j] && j == (int'(ptr_q) + i) % WIDTH) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o = j[IDX_W-1:0];
        end
    ptr_d = !adv_i ? ptr_q : (int'(adv_idx_i) == WIDTH - 1) ? '0 : adv_idx_i + IDX_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/armleo_axi_read_mux_mo.sv
// armleo_axi_read_mux_mo: N-host AXI read mux with per-host outstanding-burst limits.
// Define ARMLEO_AXI_READ_MUX_MO_AR_REG_EN to register the downstream AR channel.
module armleo_axi_read_mux_mo
  import armleo_axi_pkg::*;
#(
  parameter int HOST_NUMBER = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int HIDX_W = hidx_w(HOST_NUMBER),
  localparam int DID_W = ID_WIDTH + HIDX_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [HOST_NUMBER-1:0]            upstream_axi_arvalid_i,
  output logic [HOST_NUMBER-1:0]            upstream_axi_arready_o,
  input  logic [HOST_NUMBER*ADDR_WIDTH-1:0] upstream_axi_araddr_i,
  input  logic [HOST_NUMBER*8-1:0]          upstream_axi_arlen_i,
  input  logic [HOST_NUMBER*3-1:0]          upstream_axi_arsize_i,
  input  logic [HOST_NUMBER*2-1:0]          upstream_axi_arburst_i,
  input  logic [HOST_NUMBER*ID_WIDTH-1:0]   upstream_axi_arid_i,
  input  logic [HOST_NUMBER-1:0]            upstream_axi_arlock_i,
  input  logic [HOST_NUMBER*3-1:0]          upstream_axi_arprot_i,
  output logic [HOST_NUMBER-1:0]            upstream_axi_rvalid_o,
  input  logic [HOST_NUMBER-1:0]            upstream_axi_rready_i,
  output logic [HOST_NUMBER*2-1:0]          upstream_axi_rresp_o,
  output logic [HOST_NUMBER-1:0]            upstream_axi_rlast_o,
  output logic [HOST_NUMBER*DATA_WIDTH-1:0] upstream_axi_rdata_o,
  output logic [HOST_NUMBER*ID_WIDTH-1:0]   upstream_axi_rid_o,
  output logic                              downstream_axi_arvalid_o,
  input  logic                              downstream_axi_arready_i,
  output logic [ADDR_WIDTH-1:0]             downstream_axi_araddr_o,
  output logic [7:0]                        downstream_axi_arlen_o,
  output logic [2:0]                        downstream_axi_arsize_o,
  output logic [1:0]                        downstream_axi_arburst_o,
  output logic [DID_W-1:0]                  downstream_axi_arid_o,
  output logic                              downstream_axi_arlock_o,
  output logic [2:0]                        downstream_axi_arprot_o,
  input  logic                              downstream_axi_rvalid_i,
  output logic                              downstream_axi_rready_o,
  input  logic [1:0]                        downstream_axi_rresp_i,
  input  logic                              downstream_axi_rlast_i,
  input  logic [DATA_WIDTH-1:0]             downstream_axi_rdata_i,
  input  logic [DID_W-1:0]                  downstream_axi_rid_i
);
  localparam int PW = ADDR_WIDTH + 8 + 3 + 2 + DID_W + 1 + 3;
  logic [7:0] cnt_q [HOST_NUMBER];
  logic [7:0] cnt_d [HOST_NUMBER];
  logic [HOST_NUMBER-1:0] elig, inc, dec;
  logic lock_q, lock_d, rr_valid, arb_valid, arb_ready, hs_ar;
  logic [HIDX_W-1:0] lock_idx_q, rr_idx, sel, ridx;
  logic sel_arvalid, sel_arlock, r_known, r_cnt_nz, r_host_rdy, fwd;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [7:0] sel_arlen;
  logic [2:0] sel_arsize, sel_arprot;
  logic [1:0] sel_arburst;
  logic [ID_WIDTH-1:0] sel_arid;
  logic [PW-1:0] ar_payload, ds_payload;
  always_comb
    for (int h = 0; h < HOST_NUMBER; h++)
      elig[h] = rst_n && upstream_axi_arvalid_i[h] && int'(cnt_q[h]) < MAX_OUTSTANDING;
  armleo_round_robin #(.WIDTH(HOST_NUMBER), .IDX_W(HIDX_W)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_i(elig), .adv_i(hs_ar), .adv_idx_i(sel),
    .gnt_valid_o(rr_valid), .gnt_idx_o(rr_idx)
  );
  // A stalled grant stays locked so the downstream ARVALID/payload remain stable
  assign sel = lock_q ? lock_idx_q : rr_idx;
  assign arb_valid = rst_n && (lock_q ? sel_arvalid : rr_valid);
  assign hs_ar = arb_valid && arb_ready;
  assign lock_d = arb_valid && !arb_ready;
  always_comb begin
    sel_arvalid = 1'b0;
    sel_araddr = '0;
    sel_arlen = '0;
    sel_arsize = '0;
    sel_arburst = '0;
    sel_arid = '0;
    sel_arlock = 1'b0;
    sel_arprot = '0;
    for (int h = 0; h < HOST_NUMBER; h++)
      if (int'(sel) == h) begin
        sel_arvalid = upstream_axi_arvalid_i[h];
        sel_araddr = upstream_axi_araddr_i[h*ADDR_WIDTH +: ADDR_WIDTH];
        sel_arlen = upstream_axi_arlen_i[h*8 +: 8];
        sel_arsize = upstream_axi_arsize_i[h*3 +: 3];
        sel_arburst = upstream_axi_arburst_i[h*2 +: 2];
        sel_arid = upstream_axi_arid_i[h*ID_WIDTH +: ID_WIDTH];
        sel_arlock = upstream_axi_arlock_i[h];
        sel_arprot = upstream_axi_arprot_i[h*3 +: 3];
      end
  end
  assign ar_payload = {sel_araddr, sel_arlen, sel_arsize, sel_arburst,
                       DID_W'(make_id(32'(sel), 32'(sel_arid), ID_WIDTH)), sel_arlock, sel_arprot};
`ifdef ARMLEO_AXI_READ_MUX_MO_AR_REG_EN
  armleo_axi_ar_slice #(.W(PW)) u_ar_slice (
    .clk(clk), .rst_n(rst_n), .s_valid_i(arb_valid), .s_ready_o(arb_ready), .s_data_i(ar_payload),
    .m_valid_o(downstream_axi_arvalid_o), .m_ready_i(downstream_axi_arready_i), .m_data_o(ds_payload)
  );
`else
  assign downstream_axi_arvalid_o = arb_valid;
  assign arb_ready = downstream_axi_arready_i;
  assign ds_payload = ar_payload;
`endif
  assign {downstream_axi_araddr_o, downstream_axi_arlen_o, downstream_axi_arsize_o, downstream_axi_arburst_o,
          downstream_axi_arid_o, downstream_axi_arlock_o, downstream_axi_arprot_o} = ds_payload;
  // Beats for unknown hosts or hosts with nothing outstanding are sunk, never forwarded
  assign ridx = downstream_axi_rid_i[DID_W-1:ID_WIDTH];
  always_comb begin
    r_known = 1'b0;
    r_cnt_nz = 1'b0;
    r_host_rdy = 1'b0;
    for (int h = 0; h < HOST_NUMBER; h++)
      if (int'(ridx) == h) begin
        r_known = 1'b1;
        r_cnt_nz = cnt_q[h] != 8'd0;
        r_host_rdy = upstream_axi_rready_i[h];
      end
  end
  assign fwd = rst_n && r_known && r_cnt_nz;
  assign downstream_axi_rready_o = !fwd || r_host_rdy;
  assign upstream_axi_rresp_o = {HOST_NUMBER{downstream_axi_rresp_i}};
  assign upstream_axi_rlast_o = {HOST_NUMBER{downstream_axi_rlast_i}};
  assign upstream_axi_rdata_o = {HOST_NUMBER{downstream_axi_rdata_i}};
  assign upstream_axi_rid_o = {HOST_NUMBER{downstream_axi_rid_i[ID_WIDTH-1:0]}};
  always_comb
    for (int h = 0; h < HOST_NUMBER; h++) begin
      upstream_axi_rvalid_o[h] = downstream_axi_rvalid_i && fwd && int'(ridx) == h;
      dec[h] = upstream_axi_rvalid_o[h] && r_host_rdy && downstream_axi_rlast_i;
      inc[h] = hs_ar && int'(sel) == h;
      upstream_axi_arready_o[h] = inc[h];
      cnt_d[h] = (inc[h] && !dec[h]) ? cnt_q[h] + 8'd1 : (dec[h] && !inc[h]) ? cnt_q[h] - 8'd1 : cnt_q[h];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int h = 0; h < HOST_NUMBER; h++) cnt_q[h] <= 8'd0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int h = 0; h < HOST_NUMBER; h++) cnt_q[h] <= cnt_d[h];
      lock_q <= lock_d;
      lock_idx_q <= sel;
    end
endmodule
